alarm_timekeeper: RTL and testbench

Downstream consumer of the set/alarm router. Keeps running BCD time of day from the 25 MHz clock, loads time from the routed set-time values while `set_time` is held, and compares against the routed alarm values. A three-state alarm FSM (idle / ringing / snoozing) drives the display and buzzer stages.

---
 rtl/alarm_timekeeper.sv | 194 +++++++++++++++++++
 tb/tb_alarm_timekeeper.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timekeeper.sv
// alarm_timekeeper: BCD time-of-day counter with set-time load and a
// three-state alarm FSM (idle / ringing / snoozing).
`timescale 1ns/1ps
module alarm_timekeeper #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic       MHz_25,
  input  logic       reset,
  input  logic       set_time,
  input  logic [7:0] hours_set,
  input  logic [7:0] minutes_set,
  input  logic [7:0] hours_alarm,
  input  logic [7:0] minutes_alarm,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       tick_1hz,
  output logic       alarm_on,
  output logic       snoozing
);

  localparam int unsigned   PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam int unsigned   RW         = $clog2(RING_SEC + 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_SEC - 1);
  localparam logic [6:0]    SNZ        = 7'(SNOOZE_MIN);

  // Each output flag owns one state bit so alarm_on/snoozing come straight
  // from flops with no decode.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hours_q, hours_d;
  logic [7:0]    minutes_q, minutes_d;
  logic [7:0]    seconds_q, seconds_d;
  logic          tick_q;
  logic          tick;
  logic          set_valid;
  logic          on_zero;
  logic          alarm_hit;
  logic          snooze_hit;
  state_t        state_q;
  logic [RW-1:0] ring_cnt_q;
  logic [7:0]    snz_h_q, snz_m_q;
  logic [7:0]    snz_h_d, snz_m_d;
  logic [6:0]    min_sum;
  logic [6:0]    hr_sum;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return {3'b000, v[7:4]} * 7'd10 + {3'b000, v[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [7:0] w;
    w = {1'b0, v};
    return ((w / 8'd10) << 4) | (w % 8'd10);
  endfunction

  assign set_valid = (hours_set[7:4] <= 4'd9) && (hours_set[3:0] <= 4'd9) &&
                     (minutes_set[7:4] <= 4'd9) && (minutes_set[3:0] <= 4'd9) &&
                     (hours_set <= 8'h23) && (minutes_set <= 8'h59);

  // Next time of day: set-time load, 1 Hz BCD advance, or prescaler count.
  always_comb begin
    presc_d   = presc_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    tick      = 1'b0;
    if (set_time) begin
      presc_d   = '0;
      seconds_d = '0;
      if (set_valid) begin
        hours_d   = hours_set;
        minutes_d = minutes_set;
      end
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick    = 1'b1;
      if (seconds_q == 8'h59) begin
        seconds_d = '0;
        if (minutes_q == 8'h59) begin
          minutes_d = '0;
          hours_d   = (hours_q == 8'h23) ? '0 : bcd_inc(hours_q);
        end else begin
          minutes_d = bcd_inc(minutes_q);
        end
      end else begin
        seconds_d = bcd_inc(seconds_q);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // A match only happens on a tick that lands on hh:mm:00; loads never tick.
  assign on_zero    = tick && (seconds_q == 8'h59);
  assign alarm_hit  = on_zero && (hours_d == hours_alarm) && (minutes_d == minutes_alarm);
  assign snooze_hit = on_zero && (hours_d == snz_h_q) && (minutes_d == snz_m_q);

  // Snooze target: current hh:mm plus SNOOZE_MIN, wrapping at 24:00.
  always_comb begin
    min_sum = bcd2bin(minutes_q) + SNZ;
    hr_sum  = bcd2bin(hours_q);
    if (min_sum >= 7'd60) begin
      min_sum = min_sum - 7'd60;
      hr_sum  = hr_sum + 7'd1;
    end
    if (hr_sum >= 7'd24) hr_sum = '0;
    snz_h_d = bin2bcd(hr_sum);
    snz_m_d = bin2bcd(min_sum);
  end

  // Time-of-day, prescaler and tick registers.
  always_ff @(posedge MHz_25) begin
    if (reset) begin
      presc_q   <= '0;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      tick_q    <= tick;
    end
  end

  // Alarm FSM with ring-timeout counter and latched snooze target.
  always_ff @(posedge MHz_25) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_h_q    <= '0;
      snz_m_q    <= '0;
    end else if (set_time || !alarm_en) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_hit) begin
            state_q    <= RINGING;
            ring_cnt_q <= '0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_q <= IDLE;
          end else if (snooze) begin
            state_q <= SNOOZE;
            snz_h_q <= snz_h_d;
            snz_m_q <= snz_m_d;
          end else if (tick) begin
            if (ring_cnt_q == RING_LAST) state_q <= IDLE;
            else                         ring_cnt_q <= ring_cnt_q + RW'(1);
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state_q <= IDLE;
          end else if (snooze_hit) begin
            state_q    <= RINGING;
            ring_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hours    = hours_q;
  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign tick_1hz = tick_q;
  assign alarm_on = state_q[0];
  assign snoozing = state_q[1];

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Scoreboard bench for alarm_timekeeper (CLK_HZ=4, SNOOZE_MIN=9, RING_SEC=60).
`timescale 1ns/1ps
module tb_alarm_timekeeper;

  localparam int unsigned S_HH = 0, S_MM = 1, S_SS = 2, S_TICK = 3,
                          S_ALM = 4, S_SNZ = 5, S_TCNT = 6, S_MARK = 7;

  typedef struct {
    int unsigned cyc;
    int unsigned sel;
    logic [7:0]  val;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, set_time, alarm_en, snooze, dismiss;
  logic [7:0] hours_set, minutes_set, hours_alarm, minutes_alarm;
  logic [7:0] hours, minutes, seconds;
  logic       tick_1hz, alarm_on, snoozing;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tick_seen = 0;
  int unsigned tick_base = 0;
  int unsigned R, R2, R3, R4;

  alarm_timekeeper #(.CLK_HZ(4), .SNOOZE_MIN(9), .RING_SEC(60)) dut (
    .MHz_25(clk), .reset(reset), .set_time(set_time),
    .hours_set(hours_set), .minutes_set(minutes_set),
    .hours_alarm(hours_alarm), .minutes_alarm(minutes_alarm),
    .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .tick_1hz(tick_1hz), .alarm_on(alarm_on), .snoozing(snoozing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic exp_at(input int unsigned c, input int unsigned sel,
                        input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_time(input int unsigned c, input logic [7:0] h,
                          input logic [7:0] m, input logic [7:0] s, input string nm);
    exp_at(c, S_HH, h, {nm, ".hh"});
    exp_at(c, S_MM, m, {nm, ".mm"});
    exp_at(c, S_SS, s, {nm, ".ss"});
  endtask

  task automatic exp_flags(input int unsigned c, input logic a, input logic s, input string nm);
    exp_at(c, S_ALM, {7'b0, a}, {nm, ".alarm_on"});
    exp_at(c, S_SNZ, {7'b0, s}, {nm, ".snoozing"});
  endtask

  task automatic exp_reset_vals(input int unsigned c, input string nm);
    exp_time(c, 8'h00, 8'h00, 8'h00, nm);
    exp_at(c, S_TICK, 8'h00, {nm, ".tick"});
    exp_flags(c, 1'b0, 1'b0, nm);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int unsigned c);
    if (c > cyc) step(c - cyc);
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m);
    hours_set = h; minutes_set = m; set_time = 1'b1;
    step(1);
    set_time = 1'b0;
  endtask

  // Monitor: pops expectations due at the current cycle and compares.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [7:0] act;
    if (tick_1hz === 1'b1) tick_seen++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.sel == S_MARK) begin
        tick_base = tick_seen;
      end else begin
        case (e.sel)
          S_HH:    act = hours;
          S_MM:    act = minutes;
          S_SS:    act = seconds;
          S_TICK:  act = {7'b0, tick_1hz};
          S_ALM:   act = {7'b0, alarm_on};
          S_SNZ:   act = {7'b0, snoozing};
          S_TCNT:  act = 8'(tick_seen - tick_base);
          default: act = 8'hxx;
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %h expected %h", e.name, cyc, act, e.val);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; set_time = 1'b0; alarm_en = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    hours_set = '0; minutes_set = '0; hours_alarm = '0; minutes_alarm = '0;

    // Reset and free run for 60 ticks.
    step(2);
    R = cyc;
    exp_reset_vals(R, "rst");
    exp_at(R, S_MARK, 8'h00, "mark");
    reset = 1'b0;
    exp_at(R + 3, S_SS, 8'h00, "pre_tick.ss");
    exp_at(R + 4, S_SS, 8'h01, "tick1.ss");
    exp_at(R + 4, S_TICK, 8'h01, "tick1.tick");
    exp_at(R + 5, S_TICK, 8'h00, "tick1_end.tick");
    exp_time(R + 236, 8'h00, 8'h00, 8'h59, "t59");
    exp_time(R + 240, 8'h00, 8'h01, 8'h00, "t60");
    exp_at(R + 240, S_TCNT, 8'd60, "tick_count");
    step_to(R + 240);

    // Load 23:59 and roll over midnight.
    load(8'h23, 8'h59);
    R = cyc;
    exp_time(R, 8'h23, 8'h59, 8'h00, "load2359");
    exp_time(R + 236, 8'h23, 8'h59, 8'h59, "pre_midnight");
    exp_time(R + 240, 8'h00, 8'h00, 8'h00, "midnight");
    step_to(R + 240);

    // Invalid loads keep the previous time.
    load(8'h12, 8'h34);
    exp_time(cyc, 8'h12, 8'h34, 8'h00, "load1234");
    load(8'h24, 8'h30);
    exp_at(cyc, S_HH, 8'h12, "bad_h24.hh");
    exp_at(cyc, S_MM, 8'h34, "bad_h24.mm");
    load(8'h10, 8'h5A);
    exp_at(cyc, S_HH, 8'h12, "bad_m5a.hh");
    exp_at(cyc, S_MM, 8'h34, "bad_m5a.mm");
    load(8'h1A, 8'h00);
    exp_at(cyc, S_HH, 8'h12, "bad_h1a.hh");
    exp_at(cyc, S_MM, 8'h34, "bad_h1a.mm");

    // Alarm 07:30, ring and dismiss, no re-ring within the minute.
    hours_alarm = 8'h07; minutes_alarm = 8'h30; alarm_en = 1'b1;
    load(8'h07, 8'h29);
    R = cyc;
    exp_flags(R + 239, 1'b0, 1'b0, "pre_ring");
    exp_time(R + 240, 8'h07, 8'h30, 8'h00, "ring0730");
    exp_flags(R + 240, 1'b1, 1'b0, "ring0730");
    step_to(R + 240);
    dismiss = 1'b1; step(1); dismiss = 1'b0;
    exp_flags(cyc, 1'b0, 1'b0, "dismissed");
    exp_at(R + 400, S_ALM, 8'h00, "no_rering.alarm_on");
    exp_at(R + 480, S_MM, 8'h31, "after0731.mm");
    exp_at(R + 480, S_ALM, 8'h00, "after0731.alarm_on");
    step_to(R + 480);

    // Ring at 23:55, snooze to 00:04, then unattended timeout.
    hours_alarm = 8'h23; minutes_alarm = 8'h55;
    load(8'h23, 8'h54);
    R = cyc;
    exp_flags(R + 240, 1'b1, 1'b0, "ring2355");
    step_to(R + 240);
    snooze = 1'b1; step(1); snooze = 1'b0;
    exp_flags(cyc, 1'b0, 1'b1, "snoozed");
    exp_time(R + 2399, 8'h00, 8'h03, 8'h59, "pre_snz_end");
    exp_flags(R + 2399, 1'b0, 1'b1, "pre_snz_end");
    R2 = R + 2400;
    exp_time(R2, 8'h00, 8'h04, 8'h00, "snz_end");
    exp_flags(R2, 1'b1, 1'b0, "snz_end");
    exp_at(R2 + 239, S_ALM, 8'h01, "ring59.alarm_on");
    exp_time(R2 + 240, 8'h00, 8'h05, 8'h00, "timeout");
    exp_flags(R2 + 240, 1'b0, 1'b0, "timeout");
    step_to(R2 + 240);

    // Ring then drop alarm_en.
    hours_alarm = 8'h00; minutes_alarm = 8'h06;
    exp_at(R2 + 480, S_MM, 8'h06, "ring0006.mm");
    exp_at(R2 + 480, S_ALM, 8'h01, "ring0006.alarm_on");
    step_to(R2 + 480);
    alarm_en = 1'b0; step(1); alarm_en = 1'b1;
    exp_flags(cyc, 1'b0, 1'b0, "en_drop");

    // Dismiss and snooze together while ringing.
    hours_alarm = 8'h10; minutes_alarm = 8'h01;
    load(8'h10, 8'h00);
    R3 = cyc;
    exp_flags(R3 + 240, 1'b1, 1'b0, "ring1001");
    step_to(R3 + 240);
    dismiss = 1'b1; snooze = 1'b1; step(1); dismiss = 1'b0; snooze = 1'b0;
    exp_flags(cyc, 1'b0, 1'b0, "dis_snz");
    exp_flags(R3 + 260, 1'b0, 1'b0, "dis_snz_later");
    step_to(R3 + 260);

    // set_time while snoozing.
    minutes_alarm = 8'h02;
    exp_flags(R3 + 480, 1'b1, 1'b0, "ring1002");
    step_to(R3 + 480);
    snooze = 1'b1; step(1); snooze = 1'b0;
    exp_flags(cyc, 1'b0, 1'b1, "snoozed2");
    load(8'h15, 8'h45);
    R4 = cyc;
    exp_time(R4, 8'h15, 8'h45, 8'h00, "set_in_snz");
    exp_flags(R4, 1'b0, 1'b0, "set_in_snz");

    // Reset mid-ring.
    hours_alarm = 8'h15; minutes_alarm = 8'h46;
    exp_flags(R4 + 240, 1'b1, 1'b0, "ring1546");
    exp_at(R4 + 240, S_TICK, 8'h01, "ring1546.tick");
    step_to(R4 + 240);
    reset = 1'b1; step(1); reset = 1'b0;
    exp_reset_vals(cyc, "mid_ring_rst");

    step(4);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel != S_MARK) begin
        checks++;
        errors++;
        $display("FAIL %s: never checked, expected %h at cycle %0d", e.name, e.val, e.cyc);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
